// File: rtl/gsm_pkg.sv
// rtl/gsm_pkg.sv - shared defaults and FSM encoding for the gsm egress drain
package gsm_pkg;

  localparam int GSM_DWIDTH      = 128;
  localparam int GSM_LWIDTH      = 7;
  localparam int GSM_LOC_PKT_LEN = 24;

  // HDR: the next popped cell is a header; BODY: body cells still outstanding
  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } gsm_state_t;

endpackage

// File: rtl/gsm_skid_buf.sv
// rtl/gsm_skid_buf.sv - two-entry in-order skid buffer, head entry drives the output
module gsm_skid_buf #(
  parameter int WIDTH = 130
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0]       count_q;
  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot1_q;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Slot 0 is always the head; it only changes on a pop or on a write into an empty buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= in_data;
          else                 slot1_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        // Push and pop together only happen with exactly one entry held
        2'b11: slot0_q <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gsm_egress_drain.sv
// rtl/gsm_egress_drain.sv - drains gsm egress cells into sop/eop framed beats (stats ports under GSM_EGRESS_STATS_EN)
module gsm_egress_drain
  import gsm_pkg::*;
#(
  parameter int DWIDTH      = GSM_DWIDTH,
  parameter int LWIDTH      = GSM_LWIDTH,
  parameter int LOC_PKT_LEN = GSM_LOC_PKT_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_egress_valid,
  input  logic [DWIDTH-1:0] i_egress_data,
  output logic              o_egress_rd,
  output logic              o_pkt_valid,
  output logic              o_pkt_sop,
  output logic              o_pkt_eop,
  output logic [DWIDTH-1:0] o_pkt_data,
  input  logic              i_pkt_ready,
  output logic              o_len_err
`ifdef GSM_EGRESS_STATS_EN
  ,
  output logic [31:0]       o_pkt_cnt,
  output logic [15:0]       o_err_cnt
`endif
);

  localparam int BW = DWIDTH + 2;

  gsm_state_t        state_q, state_d;
  logic [LWIDTH-1:0] rem_q, rem_d;
  logic [LWIDTH-1:0] hdr_len;
  logic              pop;
  logic              push;
  logic              beat_sop;
  logic              beat_eop;
  logic              len_err_d;
  logic              len_err_q;
  logic              buf_in_ready;
  logic              buf_out_valid;
  logic [BW-1:0]     buf_out;

  assign hdr_len     = i_egress_data[LOC_PKT_LEN+LWIDTH-1:LOC_PKT_LEN];
  // Reset gates the pop so the upstream FIFO is never drained while held in reset
  assign pop         = i_egress_valid & buf_in_ready & ~rst;
  assign o_egress_rd = pop;
  assign o_len_err   = len_err_q;

  // Register framing state, remaining body count and the delayed length-error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HDR;
      rem_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      len_err_q <= len_err_d;
    end
  end

  // Classify each popped cell as header or body and decide its sop/eop marking
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    push      = 1'b0;
    beat_sop  = 1'b0;
    beat_eop  = 1'b0;
    len_err_d = 1'b0;
    if (pop) begin
      case (state_q)
        ST_HDR: begin
          if (hdr_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            push     = 1'b1;
            beat_sop = 1'b1;
            if (hdr_len == LWIDTH'(1)) begin
              beat_eop = 1'b1;
            end else begin
              rem_d   = hdr_len - LWIDTH'(1);
              state_d = ST_BODY;
            end
          end
        end
        ST_BODY: begin
          push  = 1'b1;
          rem_d = rem_q - LWIDTH'(1);
          if (rem_q == LWIDTH'(1)) begin
            beat_eop = 1'b1;
            state_d  = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  gsm_skid_buf #(
    .WIDTH (BW)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_data   ({beat_sop, beat_eop, i_egress_data}),
    .in_ready  (buf_in_ready),
    .out_valid (buf_out_valid),
    .out_data  (buf_out),
    .out_ready (i_pkt_ready)
  );

  assign o_pkt_valid = buf_out_valid;
  assign o_pkt_sop   = buf_out[BW-1];
  assign o_pkt_eop   = buf_out[BW-2];
  assign o_pkt_data  = buf_out[DWIDTH-1:0];

`ifdef GSM_EGRESS_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;

  // Count transferred end-of-packet beats and dropped zero-length headers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (o_pkt_valid & i_pkt_ready & o_pkt_eop) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (len_err_q)                             err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_pkt_cnt = pkt_cnt_q;
  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_gsm_egress_drain.sv
// tb/tb_gsm_egress_drain.sv - directed self-checking bench for gsm_egress_drain
module tb_gsm_egress_drain;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          egress_valid = 1'b0;
  logic [DW-1:0] egress_data = '0;
  logic          egress_rd;
  logic          pkt_valid;
  logic          pkt_sop;
  logic          pkt_eop;
  logic [DW-1:0] pkt_data;
  logic          pkt_ready = 1'b1;
  logic          len_err;
`ifdef GSM_EGRESS_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [15:0]   err_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  gsm_egress_drain dut (
    .clk            (clk),
    .rst            (rst),
    .i_egress_valid (egress_valid),
    .i_egress_data  (egress_data),
    .o_egress_rd    (egress_rd),
    .o_pkt_valid    (pkt_valid),
    .o_pkt_sop      (pkt_sop),
    .o_pkt_eop      (pkt_eop),
    .o_pkt_data     (pkt_data),
    .i_pkt_ready    (pkt_ready),
    .o_len_err      (len_err)
`ifdef GSM_EGRESS_STATS_EN
    ,
    .o_pkt_cnt      (pkt_cnt),
    .o_err_cnt      (err_cnt)
`endif
  );

  // cell with length field at bit 24 and a tag in the top word
  function automatic logic [DW-1:0] mk(input int len, input int tag);
    logic [DW-1:0] c;
    c          = '0;
    c[24 +: 7] = len[6:0];
    c[127:96]  = tag;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input string tag, input logic s, input logic e, input logic [DW-1:0] d);
    chk({tag, "_vse"}, {pkt_valid, pkt_sop, pkt_eop}, {1'b1, s, e});
    chk({tag, "_data"}, pkt_data, d);
  endtask

  initial begin
    #1 rst = 1'b1;
    egress_valid = 1'b1;
    egress_data  = mk(1, 'h99);
    #2;
    chk("rst_rd", egress_rd, 0);
    chk("rst_vse", {pkt_valid, pkt_sop, pkt_eop}, 0);
    chk("rst_data", pkt_data, 0);
    chk("rst_err", len_err, 0);
    tick(); tick();
    rst = 1'b0;

    // len=3 packet, body cells carry a zero length field that must not be interpreted
    egress_data = mk(3, 'hA0); #1;
    chk("a_rd", egress_rd, 1);
    chk("a_idle", pkt_valid, 0);
    tick(); egress_data = mk(0, 'hA1); #1 beat("a1", 1, 0, mk(3, 'hA0));
    tick(); egress_data = mk(0, 'hA2); #1 beat("a2", 0, 0, mk(0, 'hA1));
    tick(); egress_data = mk(1, 'hB0); #1 beat("a3", 0, 1, mk(0, 'hA2));
    // len=1 then back-to-back len=2
    tick(); egress_data = mk(2, 'hB1); #1 beat("b0", 1, 1, mk(1, 'hB0));
    tick(); egress_data = mk(0, 'hB2); #1 beat("b1", 1, 0, mk(2, 'hB1));
    tick(); egress_data = mk(0, 'hC0); #1 beat("b2", 0, 1, mk(0, 'hB2));
    // len=0 header dropped with a one-cycle error pulse, then len=1 forwarded
    tick(); egress_data = mk(1, 'hC1); #1;
    chk("c0_nobeat", pkt_valid, 0);
    chk("c0_err", len_err, 1);
    tick(); egress_valid = 1'b0; #1;
    beat("c1", 1, 1, mk(1, 'hC1));
    chk("c1_err", len_err, 0);
    tick(); #1;
    chk("c_idle", pkt_valid, 0);
`ifdef GSM_EGRESS_STATS_EN
    chk("c_err_cnt", err_cnt, 1);
    chk("c_pkt_cnt", pkt_cnt, 4);
`endif

    // len=5 with backpressure after the first beat transfers
    egress_valid = 1'b1; egress_data = mk(5, 'hD0); #1;
    chk("d0_rd", egress_rd, 1);
    tick(); egress_data = mk(0, 'hD1); #1 beat("d0", 1, 0, mk(5, 'hD0));
    tick(); pkt_ready = 1'b0; egress_data = mk(0, 'hD2); #1;
    beat("d1", 0, 0, mk(0, 'hD1));
    chk("d2_rd", egress_rd, 1);
    tick(); egress_data = mk(0, 'hD3); #1;
    chk("d_full_rd", egress_rd, 0);
    beat("d1_hold", 0, 0, mk(0, 'hD1));
    tick(); #1;
    chk("d_full_rd2", egress_rd, 0);
    beat("d1_hold2", 0, 0, mk(0, 'hD1));
    pkt_ready = 1'b1; #1;
    chk("d_full_rd3", egress_rd, 0);
    tick(); #1;
    beat("d2", 0, 0, mk(0, 'hD2));
    chk("d3_rd", egress_rd, 1);
    tick(); egress_data = mk(0, 'hD4); #1 beat("d3", 0, 0, mk(0, 'hD3));
    tick(); egress_valid = 1'b0; #1 beat("d4", 0, 1, mk(0, 'hD4));
    tick(); #1;
    chk("d_idle", pkt_valid, 0);
`ifdef GSM_EGRESS_STATS_EN
    chk("d_pkt_cnt", pkt_cnt, 5);
`endif

    // reset in BODY with 4 cells outstanding, next cell is a header again
    egress_valid = 1'b1; egress_data = mk(5, 'hE0);
    tick(); egress_data = mk(0, 'hE1); #1 beat("e0", 1, 0, mk(5, 'hE0));
    rst = 1'b1; #1;
    chk("e_rst_vse", {pkt_valid, pkt_sop, pkt_eop}, 0);
    chk("e_rst_data", pkt_data, 0);
    chk("e_rst_rd", egress_rd, 0);
    tick(); rst = 1'b0; egress_data = mk(2, 'hF0); #1;
    chk("f0_rd", egress_rd, 1);
    tick(); egress_data = mk(0, 'hF1); #1 beat("f0", 1, 0, mk(2, 'hF0));
    tick(); egress_valid = 1'b0; #1 beat("f1", 0, 1, mk(0, 'hF1));
    tick(); #1;
    chk("f_idle", pkt_valid, 0);

`ifdef GSM_EGRESS_STATS_EN
    chk("f_pkt_cnt", pkt_cnt, 1);
    chk("f_err_cnt", err_cnt, 0);
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt_q;
    egress_valid = 1'b1; egress_data = mk(1, 'hA5);
    tick(); egress_valid = 1'b0; #1 beat("g0", 1, 1, mk(1, 'hA5));
    tick(); #1;
    chk("g_wrap", pkt_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gsm_egress_drain.md
GSM_EGRESS_DRAIN -- requirements
Module: gsm_egress_drain

Interface
REQ-001 Parameter DWIDTH, default 128, SHALL be the cell width in bits.
REQ-002 Parameter LWIDTH, default 7, SHALL be the width of the header length field in cells.
REQ-003 Parameter LOC_PKT_LEN, default 24, SHALL be the bit location of the length field LSB within the header cell.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock (80 MHz egress domain).
REQ-005 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-006 Port i_egress_valid, input, 1 bit, SHALL indicate that the gsm unit egress port presents a cell (show-ahead).
REQ-007 Port i_egress_data, input, DWIDTH bits, SHALL be the presented cell.
REQ-008 Port o_egress_rd, output, 1 bit, SHALL pop the presented cell in the same cycle.
REQ-009 Port o_pkt_valid, output, 1 bit, SHALL qualify the downstream beat.
REQ-010 Port o_pkt_sop / o_pkt_eop, output, 1 bit each, SHALL mark the first and last beat of a packet.
REQ-011 Port o_pkt_data, output, DWIDTH bits, SHALL be the downstream beat data.
REQ-012 Port i_pkt_ready, input, 1 bit, SHALL be downstream backpressure; a beat transfers when o_pkt_valid and i_pkt_ready are both high.
REQ-013 Port o_len_err, output, 1 bit, SHALL pulse for one cycle when a header with length 0 is dropped.

Function
REQ-014 o_egress_rd SHALL equal i_egress_valid AND the output skid buffer having at least one free entry.
REQ-015 FSM states: HDR (next cell is a header) and BODY (remaining > 0 cells outstanding); reset state HDR.
REQ-016 In HDR, a popped cell SHALL load len = data[LOC_PKT_LEN+LWIDTH-1:LOC_PKT_LEN].
REQ-017 len = 1: beat forwarded with sop=1 and eop=1; state stays HDR.
REQ-018 len >= 2: beat forwarded with sop=1 and eop=0; remaining = len-1; go to BODY.
REQ-019 len = 0: cell popped but not forwarded; o_len_err pulses 1 cycle later; state stays HDR.
REQ-020 In BODY, each popped cell SHALL decrement remaining; the beat with remaining = 1 carries eop=1 and returns to HDR; the length field is not interpreted in BODY.
REQ-021 Latency: a cell popped in cycle N SHALL appear on o_pkt_* in cycle N+1 when the buffer was empty.
REQ-022 The skid buffer holds 2 entries; with i_pkt_ready low, at most 2 cells are popped, then o_egress_rd deasserts with no loss or reordering.
REQ-023 A simultaneous pop and downstream transfer with a full buffer SHALL be disallowed by REQ-014; with 1 entry occupied, it SHALL keep occupancy at 1.
REQ-024 o_pkt_data/sop/eop SHALL hold stable while o_pkt_valid is high and i_pkt_ready is low.
REQ-025 Full throughput: one beat per cycle when i_egress_valid and i_pkt_ready are continuously high.

Reset
REQ-026 While rst is high: o_egress_rd=0, o_pkt_valid=0, o_pkt_sop=0, o_pkt_eop=0, o_pkt_data=0, o_len_err=0, buffer empty, state HDR, remaining=0.
REQ-027 Reset mid-packet SHALL discard buffered beats; the first cell popped after release is treated as a header.

Configuration
REQ-028 With GSM_EGRESS_STATS_EN defined, the block SHALL add outputs o_pkt_cnt (32 bits, increments on each transferred eop beat) and o_err_cnt (16 bits, increments on each o_len_err). Both counters wrap, reset to 0, and have exact single-cycle increments.
REQ-029 Without GSM_EGRESS_STATS_EN, these ports and counters SHALL NOT exist.

Structure
REQ-030 Shared package gsm_pkg SHALL hold DWIDTH, LWIDTH, LOC_PKT_LEN defaults and the FSM state encoding.
REQ-031 The 2-entry buffer SHALL be the sub-module gsm_skid_buf, parameterised by width (DWIDTH+2).

Verification
REQ-032 Header len=3 followed by 2 body cells, ready=1 -> 3 beats on consecutive cycles with sop on beat 1 and eop on beat 3, first beat 1 cycle after rd.
REQ-033 Header len=1 -> single beat with sop=eop=1; a next header len=2 back-to-back -> sop on the following beat.
REQ-034 Header len=0 -> no beat, o_len_err high for exactly 1 cycle; with STATS_EN, o_err_cnt=1; a subsequent len=1 header is forwarded normally.
REQ-035 len=5, ready low after beat 1 -> exactly 2 further pops, then rd=0; ready high -> remaining beats in order, eop on beat 5.
REQ-036 rst asserted in BODY with remaining=4 -> outputs 0 immediately; after release, a cell with len=2 -> treated as a header with sop=1.
REQ-037 With STATS_EN, send 0xFFFFFFFF+1 eop beats (counter preloaded by force) -> o_pkt_cnt wraps to 0.
